hazard_ctrl_unit: RTL and testbench

//  Parametrised successor to the fixed HDU: central pipeline hazard controller for the 5-stage core.

---
 rtl/hazard_ctrl_unit.sv | 118 +++++++++++
 tb/tb_hazard_ctrl_unit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: load-use stall detection and multi-cycle redirect sequencing for the 5-stage pipeline
module hazard_ctrl_unit #(
  parameter int REG_AW   = 3,
  parameter int LOAD_LAT = 1,
  parameter int RET_LAT  = 2,
  parameter int INT_LEN  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] dec_src1,
  input  logic              dec_src1_use,
  input  logic [REG_AW-1:0] dec_src2,
  input  logic              dec_src2_use,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_dst,
  input  logic              branch_taken,
  input  logic              ret_taken,
  input  logic              int_req,
  output logic              stall,
  output logic              flush_fd,
  output logic              flush_de,
  output logic              flush_em,
  output logic              int_ack,
  output logic              busy
);
  localparam int M1 = LOAD_LAT > RET_LAT ? LOAD_LAT : RET_LAT;
  localparam int MX = M1 > INT_LEN ? M1 : INT_LEN;
  localparam int CW = $clog2(MX + 1);
  localparam int LS = LOAD_LAT > 1 ? LOAD_LAT - 2 : 0;
  typedef enum logic [2:0] {IDLE, LOAD_STALL, RET_WAIT, INT_DRAIN, INT_ACK} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          hazard, cnt_z, do_ret, int_go;
  assign hazard = ex_mem_read & ((dec_src1_use & (dec_src1 == ex_dst)) | (dec_src2_use & (dec_src2 == ex_dst)));
  assign cnt_z  = cnt_q == '0;
  // A RET preempts a load stall; all other redirects are only accepted from IDLE
  assign do_ret = ret_taken & ((state_q == IDLE) | (state_q == LOAD_STALL));
  // Next state, counter, pending interrupt and the combinational control outputs
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_z ? cnt_q : cnt_q - CW'(1);
    stall    = 1'b0;
    flush_fd = 1'b0;
    flush_de = 1'b0;
    flush_em = 1'b0;
    int_ack  = 1'b0;
    int_go   = 1'b0;
    if (do_ret) begin
      flush_fd = 1'b1;
      flush_de = 1'b1;
      flush_em = 1'b1;
      state_d  = RET_WAIT;
      cnt_d    = CW'(RET_LAT - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (branch_taken) begin
            flush_fd = 1'b1;
            flush_de = 1'b1;
          end else if (int_req | pend_q) begin
            stall    = 1'b1;
            flush_fd = 1'b1;
            int_go   = 1'b1;
            state_d  = INT_DRAIN;
            cnt_d    = CW'(INT_LEN - 1);
          end else if (hazard) begin
            stall    = 1'b1;
            flush_de = 1'b1;
            state_d  = LOAD_LAT > 1 ? LOAD_STALL : IDLE;
            cnt_d    = CW'(LS);
          end
        end
        LOAD_STALL: begin
          stall    = 1'b1;
          flush_de = 1'b1;
          state_d  = cnt_z ? IDLE : LOAD_STALL;
        end
        RET_WAIT: begin
          stall    = 1'b1;
          flush_fd = 1'b1;
          state_d  = cnt_z ? IDLE : RET_WAIT;
        end
        INT_DRAIN: begin
          stall    = 1'b1;
          flush_fd = 1'b1;
          state_d  = cnt_z ? INT_ACK : INT_DRAIN;
        end
        INT_ACK: begin
          int_ack  = 1'b1;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    pend_d = ~int_go & (pend_q | int_req);
    busy   = ~reset & (state_q != IDLE);
    if (reset) begin
      stall    = 1'b0;
      flush_fd = 1'b0;
      flush_de = 1'b0;
      flush_em = 1'b0;
      int_ack  = 1'b0;
    end
  end
  // State, counter and pending-interrupt registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: directed scenarios plus random traffic checked against a schedule-queue model
module tb_hazard_ctrl_unit;
  localparam int LOAD_LAT = 2;
  localparam int RET_LAT  = 2;
  localparam int INT_LEN  = 3;
  logic clk = 1'b0, reset = 1'b1;
  logic [2:0] dec_src1 = '0, dec_src2 = '0, ex_dst = '0;
  logic dec_src1_use = 1'b0, dec_src2_use = 1'b0, ex_mem_read = 1'b0;
  logic branch_taken = 1'b0, ret_taken = 1'b0, int_req = 1'b0;
  logic stall, flush_fd, flush_de, flush_em, int_ack, busy;
  int tests = 0, fails = 0;
  typedef struct packed {logic [5:0] o; logic ld;} ent_t;
  ent_t q[$];
  bit pend = 1'b0;

  hazard_ctrl_unit #(.REG_AW(3), .LOAD_LAT(LOAD_LAT), .RET_LAT(RET_LAT), .INT_LEN(INT_LEN)) dut (
    .clk(clk), .reset(reset),
    .dec_src1(dec_src1), .dec_src1_use(dec_src1_use),
    .dec_src2(dec_src2), .dec_src2_use(dec_src2_use),
    .ex_mem_read(ex_mem_read), .ex_dst(ex_dst),
    .branch_taken(branch_taken), .ret_taken(ret_taken), .int_req(int_req),
    .stall(stall), .flush_fd(flush_fd), .flush_de(flush_de), .flush_em(flush_em),
    .int_ack(int_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  // Output vector order: {stall, flush_fd, flush_de, flush_em, int_ack, busy}.
  // The model keeps a queue of the outputs still owed by the action in progress.
  task automatic cyc(input string tag, input bit has_e, input logic [5:0] e);
    logic [5:0] got, m;
    bit hz, svc;
    #1;
    got = {stall, flush_fd, flush_de, flush_em, int_ack, busy};
    hz = ex_mem_read && ((dec_src1_use && dec_src1 == ex_dst) || (dec_src2_use && dec_src2 == ex_dst));
    svc = 1'b0;
    if (reset) begin
      m = '0;
      q.delete();
      pend = 1'b0;
    end else begin
      if (q.size() > 0 && !(ret_taken && q[0].ld)) begin
        m = q[0].o;
        void'(q.pop_front());
      end else if (ret_taken) begin
        m = {5'b01110, q.size() > 0};
        q.delete();
        for (int i = 0; i < RET_LAT; i++) q.push_back('{6'b110001, 1'b0});
      end else if (branch_taken) begin
        m = 6'b011000;
      end else if (int_req || pend) begin
        m = 6'b110000;
        svc = 1'b1;
        for (int i = 0; i < INT_LEN; i++) q.push_back('{6'b110001, 1'b0});
        q.push_back('{6'b000011, 1'b0});
      end else if (hz) begin
        m = 6'b101000;
        for (int i = 1; i < LOAD_LAT; i++) q.push_back('{6'b101001, 1'b1});
      end else begin
        m = '0;
      end
      pend = !svc && (pend || int_req);
    end
    tests++;
    assert (got === m) else begin
      fails++;
      $error("FAIL model/%s got=%b exp=%b", tag, got, m);
    end
    if (has_e) begin
      tests++;
      assert (got === e) else begin
        fails++;
        $error("FAIL %s got=%b exp=%b", tag, got, e);
      end
    end
    @(negedge clk);
  endtask

  task automatic clr();
    {dec_src1, dec_src2, ex_dst} = '0;
    {dec_src1_use, dec_src2_use, ex_mem_read, branch_taken, ret_taken, int_req, reset} = '0;
  endtask

  initial begin
    @(negedge clk);
    reset = 1'b1; int_req = 1'b1; ret_taken = 1'b1;
    cyc("reset_a", 1, 6'b000000);
    cyc("reset_b", 1, 6'b000000);
    clr();
    cyc("idle", 1, 6'b000000);
    ex_mem_read = 1'b1; ex_dst = 3'd3; dec_src2 = 3'd3; dec_src2_use = 1'b1;
    cyc("t1_c1", 1, 6'b101000);
    cyc("t1_c2", 1, 6'b101001);
    clr();
    cyc("t1_done", 1, 6'b000000);
    ex_mem_read = 1'b1; ex_dst = 3'd3; dec_src2 = 3'd3; dec_src2_use = 1'b0;
    cyc("t2_nouse", 1, 6'b000000);
    dec_src2_use = 1'b1; ex_dst = 3'd4;
    cyc("t2_nomatch", 1, 6'b000000);
    dec_src1 = 3'd4; dec_src1_use = 1'b1;
    cyc("src1_hz", 1, 6'b101000);
    clr();
    cyc("src1_hz2", 1, 6'b101001);
    ret_taken = 1'b1; branch_taken = 1'b1;
    cyc("t3_ret", 1, 6'b011100);
    clr();
    cyc("t3_w1", 1, 6'b110001);
    cyc("t3_w2", 1, 6'b110001);
    cyc("t3_idle", 1, 6'b000000);
    ret_taken = 1'b1;
    cyc("t4_ret", 1, 6'b011100);
    ret_taken = 1'b0; int_req = 1'b1;
    cyc("t4_w1", 1, 6'b110001);
    int_req = 1'b0;
    cyc("t4_w2", 1, 6'b110001);
    cyc("t4_int", 1, 6'b110000);
    cyc("t4_d1", 1, 6'b110001);
    cyc("t4_d2", 1, 6'b110001);
    cyc("t4_d3", 1, 6'b110001);
    cyc("t4_ack", 1, 6'b000011);
    cyc("t4_idle", 1, 6'b000000);
    int_req = 1'b1;
    cyc("t5_int", 1, 6'b110000);
    int_req = 1'b0;
    cyc("t5_d1", 1, 6'b110001);
    reset = 1'b1;
    cyc("t5_rst", 1, 6'b000000);
    reset = 1'b0;
    cyc("t5_after1", 1, 6'b000000);
    cyc("t5_after2", 1, 6'b000000);
    ex_mem_read = 1'b1; ex_dst = 3'd3; dec_src1 = 3'd3; dec_src1_use = 1'b1; branch_taken = 1'b1;
    cyc("t6_br_hz", 1, 6'b011000);
    clr();
    cyc("t6_next", 1, 6'b000000);
    ex_mem_read = 1'b1; ex_dst = 3'd5; dec_src2 = 3'd5; dec_src2_use = 1'b1;
    cyc("ls_hz", 1, 6'b101000);
    ret_taken = 1'b1;
    cyc("ls_ret", 1, 6'b011101);
    clr();
    cyc("ls_w1", 1, 6'b110001);
    cyc("ls_w2", 1, 6'b110001);
    branch_taken = 1'b1; int_req = 1'b1;
    cyc("br_int", 1, 6'b011000);
    clr();
    cyc("pend_int", 1, 6'b110000);
    for (int i = 0; i < 1500; i++) begin
      reset        = $urandom_range(0, 49) == 0;
      dec_src1     = 3'($urandom);
      dec_src2     = 3'($urandom);
      ex_dst       = 3'($urandom);
      dec_src1_use = 1'($urandom);
      dec_src2_use = 1'($urandom);
      ex_mem_read  = 1'($urandom);
      branch_taken = $urandom_range(0, 7) == 0;
      ret_taken    = $urandom_range(0, 9) == 0;
      int_req      = $urandom_range(0, 11) == 0;
      cyc("rand", 0, 6'b000000);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
